uart_cmd_decoder: RTL and testbench



---
 rtl/tama_pkg.sv | 73 +++++++
 rtl/uart_cmd_decoder_if.sv | 45 ++++
 rtl/byte_edge_detect.sv | 34 +++
 rtl/uart_cmd_decoder.sv | 198 +++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/tama_pkg.sv
// Shared types, ASCII constants and byte classifier for the tamagotchi UART command path.
package tama_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_CMD,
        S_GOT_ARG,
        S_EXEC,
        S_COOLDOWN
    } state_e;

    typedef enum logic [1:0] {
        CMD_FEED,
        CMD_PLAY,
        CMD_CLEAN,
        CMD_SLEEP
    } cmd_e;

    typedef enum logic [1:0] {
        BC_LETTER,
        BC_DIGIT,
        BC_TERM,
        BC_OTHER
    } bclass_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_BANG  = 8'h21;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] CASE_MASK   = 8'hDF;

    // Clearing bit 5 folds lower-case letters onto upper-case.
    function automatic bclass_e classify(input logic [7:0] b);
        logic [7:0] u;
        bclass_e    c;
        u = b & CASE_MASK;
        c = BC_OTHER;
        unique case (1'b1)
            (u == ASCII_F) || (u == ASCII_P) ||
            (u == ASCII_C) || (u == ASCII_S):
                c = BC_LETTER;
            (b >= ASCII_1) && (b <= ASCII_9):
                c = BC_DIGIT;
            (b == ASCII_CR) || (b == ASCII_LF):
                c = BC_TERM;
            default:
                c = BC_OTHER;
        endcase
        return c;
    endfunction

    function automatic cmd_e to_cmd(input logic [7:0] b);
        logic [7:0] u;
        cmd_e       c;
        u = b & CASE_MASK;
        c = CMD_SLEEP;
        unique case (1'b1)
            (u == ASCII_F): c = CMD_FEED;
            (u == ASCII_P): c = CMD_PLAY;
            (u == ASCII_C): c = CMD_CLEAN;
            default:        c = CMD_SLEEP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / action-out bundle of the UART command decoder.
// Echo signals exist only when UART_CMD_ECHO_EN is defined.
interface uart_cmd_decoder_if;

    logic [7:0] rx_byte;
    logic       feed_pulse;
    logic       play_pulse;
    logic       clean_pulse;
    logic       sleep_pulse;
    logic [3:0] amount;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       busy;
`ifdef UART_CMD_ECHO_EN
    logic [7:0] echo_byte;
    logic       echo_valid;

    modport master (
        output rx_byte,
        input  feed_pulse, play_pulse, clean_pulse, sleep_pulse,
        input  amount, err_pulse, err_count, busy,
        input  echo_byte, echo_valid
    );

    modport slave (
        input  rx_byte,
        output feed_pulse, play_pulse, clean_pulse, sleep_pulse,
        output amount, err_pulse, err_count, busy,
        output echo_byte, echo_valid
    );
`else
    modport master (
        output rx_byte,
        input  feed_pulse, play_pulse, clean_pulse, sleep_pulse,
        input  amount, err_pulse, err_count, busy
    );

    modport slave (
        input  rx_byte,
        output feed_pulse, play_pulse, clean_pulse, sleep_pulse,
        output amount, err_pulse, err_count, busy
    );
`endif

endinterface

// File: rtl/byte_edge_detect.sv
// Turns the UART held-byte output into a one-cycle event per received byte.
module byte_edge_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o
);

    logic [7:0] rx_prev_q;
    logic       valid_q;
    logic       valid_d;
    logic [7:0] data_q;

    // The UART drops to 0 between bytes, so repeats of one value still fire.
    assign valid_d = (rx_byte_i != 8'h00) &&
                     ((rx_byte_i != rx_prev_q) || (rx_prev_q == 8'h00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= 8'h00;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            rx_prev_q <= rx_byte_i;
            valid_q   <= valid_d;
            data_q    <= rx_byte_i;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses "letter [digit] CR|LF" into feed/play/clean/sleep strobes.
// Define UART_CMD_ECHO_EN to add an echo byte stream for the UART transmitter.
module uart_cmd_decoder
    import tama_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 27000000,
    parameter int unsigned COOLDOWN_CYCLES = 2700000,
    parameter int unsigned DEFAULT_AMOUNT  = 1
) (
    input logic               clk,
    input logic               rst_n,
    uart_cmd_decoder_if.slave bus
);

    localparam int unsigned MAXC = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ?
                                   TIMEOUT_CYCLES : COOLDOWN_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CD_LAST = (COOLDOWN_CYCLES == 0) ?
                                        '0 : CW'(COOLDOWN_CYCLES - 1);
    localparam logic [3:0]    DEF_AMT = 4'(DEFAULT_AMOUNT);

    logic       bv;
    logic [7:0] bdata;
    bclass_e    bcls;

    state_e        state_q, state_d;
    cmd_e          cmd_q, cmd_d;
    logic [3:0]    arg_q, arg_d;
    logic [3:0]    amount_q, amount_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q;

    byte_edge_detect u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_byte_i   (bus.rx_byte),
        .byte_valid_o(bv),
        .byte_data_o (bdata)
    );

    assign bcls = classify(bdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cmd_q    <= CMD_FEED;
            arg_q    <= DEF_AMT;
            amount_q <= DEF_AMT;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            arg_q    <= arg_d;
            amount_q <= amount_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        arg_d    = arg_q;
        amount_d = amount_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bv) begin
                    unique case (bcls)
                        BC_LETTER: begin
                            cmd_d   = to_cmd(bdata);
                            arg_d   = DEF_AMT;
                            state_d = S_GOT_CMD;
                        end
                        BC_TERM: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_GOT_CMD: begin
                if (bv) begin
                    cnt_d = '0;
                    unique case (bcls)
                        BC_TERM: begin
                            amount_d = arg_q;
                            state_d  = S_EXEC;
                        end
                        BC_DIGIT: begin
                            if (cmd_q != CMD_SLEEP) begin
                                arg_d   = 4'(bdata - ASCII_0);
                                state_d = S_GOT_ARG;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GOT_ARG: begin
                if (bv) begin
                    cnt_d = '0;
                    if (bcls == BC_TERM) begin
                        amount_d = arg_q;
                        state_d  = S_EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (cnt_q == CD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.feed_pulse  = (state_q == S_EXEC) && (cmd_q == CMD_FEED);
    assign bus.play_pulse  = (state_q == S_EXEC) && (cmd_q == CMD_PLAY);
    assign bus.clean_pulse = (state_q == S_EXEC) && (cmd_q == CMD_CLEAN);
    assign bus.sleep_pulse = (state_q == S_EXEC) && (cmd_q == CMD_SLEEP);
    assign bus.amount      = amount_q;
    assign bus.err_pulse   = err_q;
    assign bus.err_count   = err_cnt_q;
    assign bus.busy        = (state_q != S_IDLE);

`ifdef UART_CMD_ECHO_EN
    logic [7:0] echo_q;
    logic       echo_v_q;
    logic       accept;

    assign accept = bv && (state_q inside {S_IDLE, S_GOT_CMD, S_GOT_ARG});

    // '?' and '!' follow the registered error/EXEC, so they land after the byte echo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_q   <= 8'h00;
            echo_v_q <= 1'b0;
        end else if (err_q) begin
            echo_q   <= ASCII_QMARK;
            echo_v_q <= 1'b1;
        end else if (state_q == S_EXEC) begin
            echo_q   <= ASCII_BANG;
            echo_v_q <= 1'b1;
        end else if (accept) begin
            echo_q   <= bdata;
            echo_v_q <= 1'b1;
        end else begin
            echo_v_q <= 1'b0;
        end
    end

    assign bus.echo_byte  = echo_q;
    assign bus.echo_valid = echo_v_q;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with short timeout/cooldown overrides.
module tb_uart_cmd_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;
    int feed_n = 0;
    int play_n = 0;
    int clean_n = 0;
    int sleep_n = 0;
    int err_n = 0;
    int base;
`ifdef UART_CMD_ECHO_EN
    logic [7:0] echo_seen[$];
`endif

    uart_cmd_decoder_if bus();

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (100),
        .COOLDOWN_CYCLES(50),
        .DEFAULT_AMOUNT (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.feed_pulse)  feed_n++;
        if (bus.play_pulse)  play_n++;
        if (bus.clean_pulse) clean_n++;
        if (bus.sleep_pulse) sleep_n++;
        if (bus.err_pulse)   err_n++;
`ifdef UART_CMD_ECHO_EN
        if (bus.echo_valid)  echo_seen.push_back(bus.echo_byte);
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte = b;
        step(2);
        bus.rx_byte = 8'h00;
        step(2);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.rx_byte = 8'h00;
        #2 rst_n = 1'b0;
        step(2);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err_count", 32'(bus.err_count), 0);
        chk("rst_amount", 32'(bus.amount), 1);
        chk("rst_pulses", 32'({bus.feed_pulse, bus.play_pulse,
            bus.clean_pulse, bus.sleep_pulse, bus.err_pulse}), 0);
        rst_n = 1'b1;
        step(2);

        // "F\r" with exact 2-cycle latency
        send("F");
        chk("f_busy", 32'(bus.busy), 1);
        bus.rx_byte = 8'h0D;
        step(1);
        chk("f_lat1", 32'(bus.feed_pulse), 0);
        step(1);
        chk("f_lat2", 32'(bus.feed_pulse), 1);
        chk("f_amount", 32'(bus.amount), 1);
        bus.rx_byte = 8'h00;
        step(1);
        chk("f_one_shot", 32'(bus.feed_pulse), 0);
        chk("f_cool_busy", 32'(bus.busy), 1);
        step(60);
        chk("f_count", feed_n, 1);
        chk("f_err", 32'(bus.err_count), 0);
        chk("f_idle", 32'(bus.busy), 0);

        // "p7\n"
        send("p");
        send("7");
        send(8'h0A);
        step(60);
        chk("p7_count", play_n, 1);
        chk("p7_amount", 32'(bus.amount), 7);
        chk("p7_feed", feed_n, 1);

        // "S3\r": digit after sleep is an error
        send("S");
        send("3");
        chk("s3_err_n", err_n, 1);
        chk("s3_err_count", 32'(bus.err_count), 1);
        chk("s3_idle", 32'(bus.busy), 0);
        send(8'h0D);
        step(5);
        chk("s3_no_sleep", sleep_n, 0);
        chk("s3_cr_ignored", 32'(bus.err_count), 1);

        // "s\r" uses default amount
        send("s");
        send(8'h0D);
        step(60);
        chk("s_count", sleep_n, 1);
        chk("s_amount", 32'(bus.amount), 1);

        // "C" then silence -> timeout
        bus.rx_byte = "C";
        step(2);
        bus.rx_byte = 8'h00;
        step(99);
        chk("to_early", 32'(bus.err_pulse), 0);
        chk("to_busy", 32'(bus.busy), 1);
        step(1);
        chk("to_err", 32'(bus.err_pulse), 1);
        chk("to_idle", 32'(bus.busy), 0);
        chk("to_err_count", 32'(bus.err_count), 2);
        send("c");
        send(8'h0D);
        step(60);
        chk("c_count", clean_n, 1);

        // bytes during cooldown are dropped silently
        send("F");
        send(8'h0D);
        send("P");
        send(8'h0D);
        step(60);
        chk("cd_feed", feed_n, 2);
        chk("cd_play", play_n, 1);
        chk("cd_err", 32'(bus.err_count), 2);
        send("P");
        send("3");
        send(8'h0D);
        step(60);
        chk("cd_after_play", play_n, 2);
        chk("cd_after_amount", 32'(bus.amount), 3);

        // saturation
        base = err_n;
        repeat (300) send("x");
        chk("sat_pulses", err_n - base, 300);
        chk("sat_count", 32'(bus.err_count), 255);

        // reset in the middle of a command
        send("F");
        chk("mid_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_err", 32'(bus.err_count), 0);
        chk("mid_rst_amount", 32'(bus.amount), 1);
        step(1);
        rst_n = 1'b1;
        step(10);
        chk("mid_no_feed", feed_n, 2);

`ifdef UART_CMD_ECHO_EN
        echo_seen.delete();
        send("f");
        send("2");
        send(8'h0D);
        step(60);
        chk("echo_f2_len", echo_seen.size(), 4);
        chk("echo_f2_0", 32'(echo_seen[0]), 32'h66);
        chk("echo_f2_1", 32'(echo_seen[1]), 32'h32);
        chk("echo_f2_2", 32'(echo_seen[2]), 32'h0D);
        chk("echo_f2_3", 32'(echo_seen[3]), 32'h21);
        echo_seen.delete();
        send("q");
        step(3);
        chk("echo_q_len", echo_seen.size(), 2);
        chk("echo_q_0", 32'(echo_seen[0]), 32'h71);
        chk("echo_q_1", 32'(echo_seen[1]), 32'h3F);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
